// File: rtl/add_round_key.sv
// AES-128 round-key addition stage with an on-the-fly forward key schedule.
// Each accepted 4x4 state matrix ([col][row] bytes) is XORed with the current
// round key and registered. The schedule then advances by one round, and it
// rewinds to the saved cipher key after round NUM_ROUNDS.

// AES forward S-box: combinational byte substitution by table lookup.
module sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  // Entry 0 sits in the most significant byte, so SBOX[x] is the substitute of x.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign out_byte = SBOX[in_byte];

endmodule

module add_round_key #(
  // Index of the final round. Only AES-128 (10) is meaningful for this schedule.
  parameter int NUM_ROUNDS = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  key_load,
  input  logic [3:0][3:0][7:0]  key_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0][3:0][7:0]  in_matrix,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [3:0][3:0][7:0]  out_matrix,
  output logic [3:0]            out_round,
  output logic                  out_last
);

  typedef logic [3:0][3:0][7:0] matrix_t;
  typedef logic [3:0][7:0]      word_t;

  localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

  // Architectural state
  matrix_t    ck_q, ck_d;          // saved cipher key, restored after the last round
  matrix_t    rk_q, rk_d;          // round key applied to the next accepted matrix
  logic [3:0] rnd_q, rnd_d;        // round index of rk_q
  logic       key_valid_q, key_valid_d;
  logic       out_valid_q, out_valid_d;
  matrix_t    out_matrix_q, out_matrix_d;
  logic [3:0] out_round_q, out_round_d;
  logic       out_last_q, out_last_d;

  // Key-expansion datapath
  word_t      sub_in;              // RotWord of the last key column
  word_t      sub_out;             // SubWord result
  logic [7:0] rcon;
  matrix_t    next_rk;

  logic       accept;
  logic       drain;

  // Handshake: no skid buffer, so a new matrix enters only when the output
  // register is empty or being drained in the same cycle.
  assign in_ready = key_valid_q & ~key_load & (~out_valid_q | out_ready);
  assign accept   = in_valid & in_ready;
  assign drain    = out_valid_q & out_ready;

  assign out_valid  = out_valid_q;
  assign out_matrix = out_matrix_q;
  assign out_round  = out_round_q;
  assign out_last   = out_last_q;

  // RotWord feeding four S-box lanes (SubWord).
  for (genvar r = 0; r < 4; r++) begin : g_subword
    assign sub_in[r] = rk_q[3][(r + 1) % 4];
    sbox u_sbox (
      .in_byte  (sub_in[r]),
      .out_byte (sub_out[r])
    );
  end

  // Round constant for the key being derived (round rnd_q + 1).
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave
    // it unassigned and infer a latch.
    rcon = 8'h00;
    case (rnd_q + 4'd1)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  // Next round key: each new column chains off the previous new column.
  always_comb begin
    word_t t;
    t       = sub_out;
    t[0]    = t[0] ^ rcon;
    next_rk = '0;
    next_rk[0] = rk_q[0] ^ t;
    next_rk[1] = rk_q[1] ^ next_rk[0];
    next_rk[2] = rk_q[2] ^ next_rk[1];
    next_rk[3] = rk_q[3] ^ next_rk[2];
  end

  // Next-state logic: key_load wins over accepts, and the output side drains independently.
  always_comb begin
    ck_d         = ck_q;
    rk_d         = rk_q;
    rnd_d        = rnd_q;
    key_valid_d  = key_valid_q;
    out_valid_d  = out_valid_q;
    out_matrix_d = out_matrix_q;
    out_round_d  = out_round_q;
    out_last_d   = out_last_q;

    if (key_load) begin
      ck_d        = key_in;
      rk_d        = key_in;
      rnd_d       = 4'd0;
      key_valid_d = 1'b1;
    end else if (accept) begin
      if (rnd_q == LAST_RND) begin
        rk_d  = ck_q;
        rnd_d = 4'd0;
      end else begin
        rk_d  = next_rk;
        rnd_d = rnd_q + 4'd1;
      end
    end

    if (accept) begin
      out_matrix_d = in_matrix ^ rk_q;
      out_round_d  = rnd_q;
      out_last_d   = (rnd_q == LAST_RND);
      out_valid_d  = 1'b1;
    end else if (drain) begin
      out_valid_d  = 1'b0;
    end
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the wide key and data registers are cleared too, not only the
      // control bits, so no stale key material survives a reset.
      ck_q         <= '0;
      rk_q         <= '0;
      rnd_q        <= 4'd0;
      key_valid_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      out_matrix_q <= '0;
      out_round_q  <= 4'd0;
      out_last_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      ck_q         <= ck_d;
      rk_q         <= rk_d;
      rnd_q        <= rnd_d;
      key_valid_q  <= key_valid_d;
      out_valid_q  <= out_valid_d;
      out_matrix_q <= out_matrix_d;
      out_round_q  <= out_round_d;
      out_last_q   <= out_last_d;
    end
  end

endmodule

// File: doc/add_round_key.md
Name: add_round_key

Overview:
- Round-key addition stage of the AES-128 encrypt datapath. It sits directly downstream of mix_columns.
- Each accepted 4x4 state matrix is XORed with the current round key, and the result is registered to the output.
- An on-the-fly key schedule advances one round key per accepted matrix. It covers round 0 (cipher key) through round 10, then rewinds to the cipher key for the next block.
- The upstream round controller muxes in the rounds that bypass mix_columns (round 0, round 10). This block XORs whatever it accepts.

Parameters:
- NUM_ROUNDS, 10, index of the final round; round counter range 0..NUM_ROUNDS. Only 10 (AES-128) is supported.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- key_load  input  1  one-cycle pulse; captures key_in as the cipher key
- key_in  input  [3:0][3:0][7:0]  cipher key, [col][row]; byte 4*col+row of the FIPS-197 key
- in_valid  input  1  in_matrix valid
- in_ready  output  1  stage can accept
- in_matrix  input  [3:0][3:0][7:0]  state from upstream, [col][row] (same layout as mix_columns)
- out_valid  output  1  out_matrix valid
- out_ready  input  1  downstream can accept
- out_matrix  output  [3:0][3:0][7:0]  in_matrix ^ round key
- out_round  output  4  round index (0..10) applied to out_matrix
- out_last  output  1  high with out_valid when out_round == NUM_ROUNDS

Behaviour:
- Reset values:
  - out_valid=0, out_matrix=0, out_round=0, out_last=0.
  - Internal: key_valid=0, rnd=0, rk=0, ck (saved cipher key)=0.
  - Reset mid-block discards all progress; a new key_load is required before further accepts.
- key_load:
  - Sets ck<=key_in, rk<=key_in, rnd<=0, key_valid<=1.
  - Takes priority over everything else. A pending output (out_valid=1) is held untouched.
  - key_load arriving mid-block aborts the block: the next accepted matrix is treated as round 0.
- Handshake:
  - in_ready = key_valid & ~key_load & (~out_valid | out_ready). This is combinational and has no skid buffer.
  - Transfer occurs when in_valid & in_ready, and when out_valid & out_ready.
  - Simultaneous output drain and input accept sustains 1 matrix per cycle.
- On an accepted input (latency 1 cycle):
  - out_matrix<=in_matrix^rk, out_round<=rnd, out_last<=(rnd==NUM_ROUNDS), out_valid<=1.
  - If rnd==NUM_ROUNDS: rk<=ck, rnd<=0 (wrap; same key reused for the next block).
  - Otherwise: rk<=next(rk, rcon[rnd+1]), rnd<=rnd+1.
- Output drained with no new accept: out_valid<=0; out_matrix, out_round and out_last hold their last values.
- out_valid=1 & out_ready=0: all outputs stable. in_ready=0, so rk and rnd are frozen.
- Key expansion next(k, rc), with column c = k[c][0..3]:
  - RotWord: t[r] = k[3][(r+1)%4].
  - SubWord: four instances of the team sbox module (combinational, 8-bit in/out); t[r] = sbox(t[r]).
  - rcon: t[0] ^= rc.
  - New columns: n[0]=k[0]^t, n[1]=k[1]^n[0], n[2]=k[2]^n[1], n[3]=k[3]^n[2].
  - rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36, produced by a case on rnd+1.
- The key schedule is purely forward; there is no decryption key path.
- in_valid with key_valid=0: not accepted (in_ready=0); no state change.

Test Plan:
- rst; key_load with key 2b7e1516 28aed2a6 abf71588 09cf4f3c; one accept of in_matrix 3243f6a8 885a308d 313198a2 e0370734 -> next cycle out_valid=1, out_matrix 193de3be a0f4e22b 9ac68d2a e9f84808, out_round=0, out_last=0.
- Same key; 11 back-to-back accepts of all-zero matrices with out_ready=1:
  - Outputs equal the round keys; round 1 = a0fafe17 88542cb1 23a33939 2a6c7605, round 10 = d014f9a8 c9ee2589 e13f0cc8 b6630ca6.
  - out_last=1 only on round 10; throughput 1 per cycle.
- Continue with a 12th zero accept -> out_round=0 and out_matrix equal to the cipher key (wrap verified).
- Backpressure: hold out_ready=0 for 5 cycles after a round-3 output -> in_ready=0, outputs stable. Releasing out_ready -> the next accept gets the round-4 key, with no round skipped or repeated.
- key_load pulse after round 5 of a block, in_valid held high that cycle -> no accept that cycle; the next accept yields out_round=0 with the new key.
- rst asserted with out_valid=1 mid-block -> next cycle out_valid=0, in_ready=0. Inputs are ignored until key_load.
